// File: rtl/muldiv_seq_if.sv
// ----------------------------------------------------------------------------
// muldiv_seq_if
//
// Bundle of the request / response / pipeline-control signals of the RV32M
// multiply/divide sequencer.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   The producer keeps its payload stable while valid is high and ready is low.
//   Valid must never depend combinationally on ready.
//
// Signals:
//   flush      pipeline -> block  kill any in-flight operation
//   in_valid   pipeline -> block  request carries an operation
//   in_ready   block -> pipeline  block can accept (idle)
//   op         pipeline -> block  funct3 of the M-extension instruction
//   rs1_data   pipeline -> block  dividend / multiplicand
//   rs2_data   pipeline -> block  divisor / multiplier
//   rd_in      pipeline -> block  destination tag
//   out_valid  block -> writeback result available
//   out_ready  writeback -> block result consumed
//   out_result block -> writeback result value
//   out_rd     block -> writeback destination tag of the result
//   busy       block -> pipeline  operation in flight or result pending
//
// Modports: master = pipeline / writeback side, slave = the sequencer.
// ----------------------------------------------------------------------------
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            busy;

    modport master (
        output flush, in_valid, op, rs1_data, rs2_data, rd_in, out_ready,
        input  in_ready, out_valid, out_result, out_rd, busy
    );

    modport slave (
        input  flush, in_valid, op, rs1_data, rs2_data, rd_in, out_ready,
        output in_ready, out_valid, out_result, out_rd, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// ----------------------------------------------------------------------------
// muldiv_seq
//
// Multi-cycle sequencer for the RV32M multiply/divide unit. One operation is
// accepted at a time; a shared datapath runs either a radix-2 shift-add
// multiplier or a restoring divider for 32 iterations, then holds the result
// until writeback takes it.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   bus          muldiv_seq_if.slave (request, response and flush/busy)
//   o_dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//   o_dbg_cnt    iteration counter
//
// Configuration macro:
//   MUXDIV_FAST_MUL_EN  when defined, multiplies complete with a single-cycle
//                       64-bit product and skip the iterative path.
//
// Datapath register usage:
//   multiply: r_a = multiplicand magnitude, {r_hi, r_lo} = accumulator whose
//             low half starts as the multiplier magnitude and shifts out
//   divide:   r_a = divisor magnitude, r_hi = partial remainder,
//             r_lo = dividend magnitude shifting into the quotient
// ----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_seq_if.slave         bus,
    output logic [1:0]          o_dbg_state,
    output logic [4:0]          o_dbg_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [4:0]      r_cnt;
    logic [2:0]      r_op;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_neg_q;     // product / quotient must be negated
    logic            r_neg_r;     // remainder must be negated
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_result;
    logic [4:0]      r_out_rd;

    // ------------------------------------------------------------------
    // Acceptance-side decode (operands straight from the request)
    // ------------------------------------------------------------------
    logic            w_signed_a;
    logic            w_signed_b;
    logic            w_is_div;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_result;

    always_comb begin
        w_signed_a = 1'b0;
        w_signed_b = 1'b0;
        case (bus.op)
            OP_MULH:        begin w_signed_a = 1'b1; w_signed_b = 1'b1; end
            OP_MULHSU:      begin w_signed_a = 1'b1; w_signed_b = 1'b0; end
            OP_DIV, OP_REM: begin w_signed_a = 1'b1; w_signed_b = 1'b1; end
            default:        begin w_signed_a = 1'b0; w_signed_b = 1'b0; end
        endcase
    end

    assign w_is_div = bus.op[2];
    assign w_a_neg  = w_signed_a & bus.rs1_data[XLEN-1];
    assign w_b_neg  = w_signed_b & bus.rs2_data[XLEN-1];
    // Magnitude of INT_MIN is 2^31, which is still correct read as unsigned.
    assign w_a_mag  = w_a_neg ? -bus.rs1_data : bus.rs1_data;
    assign w_b_mag  = w_b_neg ? -bus.rs2_data : bus.rs2_data;

    // Divide corner cases resolved at acceptance without iterating.
    assign w_div_zero = w_is_div && (bus.rs2_data == ZERO);
    assign w_div_ovf  = w_is_div && !bus.op[0] &&
                        (bus.rs1_data == INT_MIN) && (bus.rs2_data == ALL_ONES);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_result = ZERO;
        if (w_div_zero) begin
            // op[1] selects REM/REMU: remainder is the dividend itself.
            w_special_result = bus.op[1] ? bus.rs1_data : ALL_ONES;
        end else if (w_div_ovf) begin
            w_special_result = bus.op[1] ? ZERO : INT_MIN;
        end
    end

`ifdef MUXDIV_FAST_MUL_EN
    // Sign-extend to 64 bits; the low 64 bits of the unsigned product of the
    // extended operands equal the signed/mixed product.
    logic [2*XLEN-1:0] w_fast_a;
    logic [2*XLEN-1:0] w_fast_b;
    logic [2*XLEN-1:0] w_fast_prod;
    logic [XLEN-1:0]   w_fast_result;

    assign w_fast_a      = {{XLEN{w_a_neg}}, bus.rs1_data};
    assign w_fast_b      = {{XLEN{w_b_neg}}, bus.rs2_data};
    assign w_fast_prod   = w_fast_a * w_fast_b;
    assign w_fast_result = (bus.op == OP_MUL) ? w_fast_prod[XLEN-1:0]
                                              : w_fast_prod[2*XLEN-1:XLEN];
`endif

    // ------------------------------------------------------------------
    // One iteration of the shared datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_mul_hi_n;
    logic [XLEN-1:0] w_mul_lo_n;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_hi_n;
    logic [XLEN-1:0] w_div_lo_n;
    logic [XLEN-1:0] w_hi_n;
    logic [XLEN-1:0] w_lo_n;

    // Multiply: conditional add into the upper half, then shift the whole
    // 65-bit {carry, hi, lo} right by one.
    assign w_mul_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_a : ZERO)};
    assign w_mul_hi_n = w_mul_sum[XLEN:1];
    assign w_mul_lo_n = {w_mul_sum[0], r_lo[XLEN-1:1]};

    // Divide: shift {rem, quot} left, trial-subtract. The partial remainder is
    // always below the divisor, so bit XLEN of the difference is the borrow.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_a};
    assign w_div_ge    = ~w_div_diff[XLEN];
    assign w_div_hi_n  = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    assign w_div_lo_n  = {r_lo[XLEN-2:0], w_div_ge};

    assign w_hi_n = r_op[2] ? w_div_hi_n : w_mul_hi_n;
    assign w_lo_n = r_op[2] ? w_div_lo_n : w_mul_lo_n;

    // ------------------------------------------------------------------
    // Final sign correction and result select (used on the last iteration)
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quot_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_final;

    assign w_prod   = {w_hi_n, w_lo_n};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quot_s = r_neg_q ? -w_lo_n : w_lo_n;
    assign w_rem_s  = r_neg_r ? -w_hi_n : w_hi_n;

    always_comb begin
        w_final = ZERO;
        case (r_op)
            OP_MUL:                       w_final = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = w_quot_s;
            OP_REM, OP_REMU:              w_final = w_rem_s;
            default:                      w_final = ZERO;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_op         <= 3'd0;
            r_rd         <= 5'd0;
            r_a          <= ZERO;
            r_hi         <= ZERO;
            r_lo         <= ZERO;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= ZERO;
            r_out_rd     <= 5'd0;
        end else if (bus.flush) begin
            // Flush beats acceptance and consumption; a pending result is lost.
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op    <= bus.op;
                        r_rd    <= bus.rd_in;
                        r_cnt   <= 5'd0;
                        r_hi    <= ZERO;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        if (w_is_div) begin
                            r_a     <= w_b_mag;
                            r_lo    <= w_a_mag;
                            r_neg_r <= w_a_neg;
                        end else begin
                            r_a     <= w_a_mag;
                            r_lo    <= w_b_mag;
                            r_neg_r <= 1'b0;
                        end
                        if (w_special) begin
                            r_state      <= S_DONE;
                            r_out_valid  <= 1'b1;
                            r_out_result <= w_special_result;
                            r_out_rd     <= bus.rd_in;
                        end
`ifdef MUXDIV_FAST_MUL_EN
                        else if (!w_is_div) begin
                            r_state      <= S_DONE;
                            r_out_valid  <= 1'b1;
                            r_out_result <= w_fast_result;
                            r_out_rd     <= bus.rd_in;
                        end
`endif
                        else begin
                            r_state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + 5'd1;  // wraps back to 0 after the last step
                    if (r_cnt == 5'd31) begin
                        r_state      <= S_DONE;
                        r_out_valid  <= 1'b1;
                        r_out_result <= w_final;
                        r_out_rd     <= r_rd;
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state, none from request inputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.busy       = (r_state == S_CALC) || (r_state == S_DONE);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_rd     = r_out_rd;
    assign o_dbg_state    = r_state;
    assign o_dbg_cnt      = r_cnt;

endmodule

// File: tb/tb_muldiv_seq.sv
// ----------------------------------------------------------------------------
// tb_muldiv_seq
//
// Directed bench for muldiv_seq: a table of {op, operands, tag, expected
// result, expected latency} records plus hand-written sequences for the
// hold-in-DONE, flush and reset-in-DONE corner cases.
//
// Latency is counted in rising edges starting with the edge that accepts the
// request: 33 for an iterative operation, 1 for a divide corner case.
// ----------------------------------------------------------------------------
module tb_muldiv_seq;

  localparam int XLEN = 32;
`ifdef MUXDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;
  localparam int WAIT_MAX = 100;
  localparam int NVEC = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  logic [4:0] dbg_cnt;

  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_cnt   (dbg_cnt)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with the request already driven; returns the number
  // of rising edges until out_valid is seen (bounded by WAIT_MAX).
  task automatic wait_valid(output int n);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && n < WAIT_MAX) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int n;
    logic [31:0] e;
    exp_q.push_back(exp);
    bus.out_ready = 1'b1;
    drive_req(op, a, b, rd);
    wait_valid(n);
    check({name, ".lat"}, 32'(n), 32'(lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
    check({name, ".res"}, bus.out_result, e);
    check({name, ".rd"}, {27'd0, bus.out_rd}, {27'd0, rd});
    @(posedge clk);
    @(negedge clk);
    check({name, ".idle"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    logic seen;

    vecs[0]  = '{3'd0, 32'd7,         32'd6,         5'd1,  32'd42,        MUL_LAT, "mul_7x6"};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, MUL_LAT, "mulh_min"};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, MUL_LAT, "mulhsu_ff"};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, MUL_LAT, "mulhu_ff"};
    vecs[4]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001, MUL_LAT, "mul_ff"};
    vecs[5]  = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6,  32'h3FFF_FFFF, MUL_LAT, "mulh_max"};
    vecs[6]  = '{3'd1, 32'hFFFF_FFFD, 32'd5,         5'd7,  32'hFFFF_FFFF, MUL_LAT, "mulh_neg"};
    vecs[7]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, DIV_LAT, "div_m7_2"};
    vecs[8]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, DIV_LAT, "rem_m7_2"};
    vecs[9]  = '{3'd5, 32'd100,       32'd7,         5'd10, 32'd14,        DIV_LAT, "divu_100_7"};
    vecs[10] = '{3'd7, 32'd100,       32'd7,         5'd11, 32'd2,         DIV_LAT, "remu_100_7"};
    vecs[11] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, DIV_LAT, "div_7_m2"};
    vecs[12] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'd1,         DIV_LAT, "rem_7_m2"};
    vecs[13] = '{3'd4, 32'h0000_1234, 32'd0,         5'd14, 32'hFFFF_FFFF, SPC_LAT, "div_by0"};
    vecs[14] = '{3'd6, 32'h0000_1234, 32'd0,         5'd15, 32'h0000_1234, SPC_LAT, "rem_by0"};
    vecs[15] = '{3'd5, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, SPC_LAT, "divu_by0"};
    vecs[16] = '{3'd7, 32'hDEAD_BEEF, 32'd0,         5'd17, 32'hDEAD_BEEF, SPC_LAT, "remu_by0"};
    vecs[17] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, SPC_LAT, "div_ovf"};
    vecs[18] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         SPC_LAT, "rem_ovf"};
    vecs[19] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         DIV_LAT, "divu_big"};
    vecs[20] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, DIV_LAT, "remu_big"};
    vecs[21] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         5'd22, 32'hFFFF_FFFF, DIV_LAT, "divu_by1"};

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.rd_in     = 5'd0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset values
    check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.out_result", bus.out_result, 32'd0);
    check("rst.out_rd", {27'd0, bus.out_rd}, 32'd0);
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst.state", {30'd0, dbg_state}, 32'd0);
    check("rst.cnt", {27'd0, dbg_cnt}, 32'd0);

    // table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
             vecs[i].exp, vecs[i].lat);
    end

    // hold the result in DONE for 10 cycles; new requests must be ignored
    bus.out_ready = 1'b0;
    drive_req(3'd5, 32'd100, 32'd7, 5'd9);
    wait_valid(n);
    check("hold.lat", 32'(n), 32'(DIV_LAT));
    for (int i = 0; i < 10; i++) begin
      drive_req(3'd0, 32'd1, 32'd1, 5'd3);
      @(posedge clk);
      @(negedge clk);
      check("hold.res", bus.out_result, 32'd14);
      check("hold.rd", {27'd0, bus.out_rd}, 32'd9);
      check("hold.valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold.in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("release.valid", {31'd0, bus.out_valid}, 32'd0);
    check("release.busy", {31'd0, bus.busy}, 32'd0);

    // flush at counter = 15
    drive_req(3'd4, 32'd1000, 32'd3, 5'd5);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("flush.cnt", {27'd0, dbg_cnt}, 32'd15);
    check("flush.busy_pre", {31'd0, bus.busy}, 32'd1);
    check("flush.in_ready_pre", {31'd0, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush.valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush.busy", {31'd0, bus.busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("flush.no_valid", {31'd0, seen}, 32'd0);

    // flush outranks acceptance of a corner-case divide
    drive_req(3'd4, 32'd9, 32'd0, 5'd6);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_acc.valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_acc.in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op("after_flush", 3'd0, 32'd7, 32'd6, 5'd30, 32'd42, MUL_LAT);

    // reset while a result is pending in DONE
    bus.out_ready = 1'b0;
    drive_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
    wait_valid(n);
    check("rstd.lat", 32'(n), 32'(MUL_LAT));
    check("rstd.res", bus.out_result, 32'hFFFF_FFFE);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstd.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rstd.out_result", bus.out_result, 32'd0);
    check("rstd.out_rd", {27'd0, bus.out_rd}, 32'd0);
    check("rstd.busy", {31'd0, bus.busy}, 32'd0);
    check("rstd.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rstd.cnt", {27'd0, dbg_cnt}, 32'd0);

    run_op("after_rst", 3'd7, 32'd100, 32'd7, 5'd31, 32'd2, DIV_LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
